// File: rtl/id_pkg.sv
// Shared definitions for the identifier generator and its recognizer counterpart:
// the state encoding, the ASCII constants and the wrapping character steps.
package id_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LET  = 2'd1,
        DIG  = 2'd2,
        TERM = 2'd3
    } state_t;

    localparam logic [7:0] CH_A    = 8'h61;
    localparam logic [7:0] CH_Z    = 8'h7A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_TERM = 8'h2F;
    localparam logic [7:0] CH_NUL  = 8'h00;

    // Explicit compares keep the wrap cheap: no modulo hardware is needed.
    function automatic logic [7:0] next_letter(input logic [7:0] c);
        return (c == CH_Z) ? CH_A : c + 8'd1;
    endfunction

    function automatic logic [7:0] next_digit(input logic [7:0] c);
        return (c == CH_9) ? CH_0 : c + 8'd1;
    endfunction

endpackage

// File: rtl/id_char_gen.sv
// Streams `let_cnt` letters, `dig_cnt` digits and a '/' terminator, one
// character per accepted valid/ready beat.
module id_char_gen
    import id_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] let_cnt,
    input  logic [CNT_W-1:0] dig_cnt,
    input  logic             ready,
    output logic [7:0]       char,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] let_rem_q, let_rem_d;
    logic [CNT_W-1:0] dig_rem_q, dig_rem_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept = valid_q && ready;

    always_comb begin
        state_d   = state_q;
        let_rem_d = let_rem_q;
        dig_rem_d = dig_rem_q;
        char_d    = char_q;
        valid_d   = valid_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                char_d  = CH_NUL;
                if (start) begin
                    let_rem_d = let_cnt;
                    dig_rem_d = dig_cnt;
                    valid_d   = 1'b1;
                    if (let_cnt != '0) begin
                        state_d = LET;
                        char_d  = CH_A;
                    end else if (dig_cnt != '0) begin
                        state_d = DIG;
                        char_d  = CH_1;
                    end else begin
                        state_d = TERM;
                        char_d  = CH_TERM;
                    end
                end
            end
            LET: begin
                if (accept) begin
                    let_rem_d = let_rem_q - 1'b1;
                    if (let_rem_q == CNT_W'(1)) begin
                        // The digit counter is untouched during letters, so it
                        // still holds the captured digit count here.
                        if (dig_rem_q != '0) begin
                            state_d = DIG;
                            char_d  = CH_1;
                        end else begin
                            state_d = TERM;
                            char_d  = CH_TERM;
                        end
                    end else begin
                        char_d = next_letter(char_q);
                    end
                end
            end
            DIG: begin
                if (accept) begin
                    dig_rem_d = dig_rem_q - 1'b1;
                    if (dig_rem_q == CNT_W'(1)) begin
                        state_d = TERM;
                        char_d  = CH_TERM;
                    end else begin
                        char_d = next_digit(char_q);
                    end
                end
            end
            TERM: begin
                if (accept) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    char_d  = CH_NUL;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                char_d  = CH_NUL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            let_rem_q <= '0;
            dig_rem_q <= '0;
            char_q    <= CH_NUL;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            let_rem_q <= let_rem_d;
            dig_rem_q <= dig_rem_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign char  = char_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_id_char_gen.sv
// Self-checking bench for id_char_gen: every expected stream is built from the
// letter/digit/terminator rules and compared beat by beat under random stalls.
module tb_id_char_gen;

    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] let_cnt;
    logic [CNT_W-1:0] dig_cnt;
    logic             ready;
    logic [7:0]       char;
    logic             valid;
    logic             busy;
    logic             done;

    int tests_run = 0;
    int tests_failed = 0;

    id_char_gen #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .let_cnt (let_cnt),
        .dig_cnt (dig_cnt),
        .ready   (ready),
        .char    (char),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one identifier and checks every beat; outputs are sampled on the
    // falling edge, inputs for the next rising edge are applied at the same time.
    task automatic run_stream(input int lc, input int dc, input int stall_pct,
                              input logic [31:0] mask, input int mid_start,
                              input bit started, input bit chain,
                              input int nlc, input int ndc);
        logic [7:0] exp_q[$];
        int idx;
        int cyc;
        bit rdy;
        for (int i = 0; i < lc; i++) exp_q.push_back(8'h61 + 8'(i % 26));
        for (int i = 0; i < dc; i++) exp_q.push_back(8'h30 + 8'((i + 1) % 10));
        exp_q.push_back(8'h2F);

        if (!started) begin
            @(negedge clk);
            start   = 1'b1;
            let_cnt = CNT_W'(lc);
            dig_cnt = CNT_W'(dc);
            ready   = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 2000) begin
            start = (cyc == mid_start);
            if (start) begin
                let_cnt = CNT_W'($urandom_range(31, 1));
                dig_cnt = CNT_W'($urandom_range(31, 1));
            end
            tests_run++;
            if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || char !== exp_q[idx]) begin
                tests_failed++;
                $display("FAIL beat[%0d] (let=%0d dig=%0d): got valid=%b busy=%b done=%b char=%h, expected valid=1 busy=1 done=0 char=%h",
                         idx, lc, dc, valid, busy, done, char, exp_q[idx]);
            end
            if (cyc < 32 && mask[cyc]) rdy = 1'b0;
            else rdy = ($urandom_range(99, 0) >= 32'(stall_pct));
            ready = rdy;
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;

        if (idx < exp_q.size()) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stream_timeout (let=%0d dig=%0d): accepted %0d of %0d characters",
                     lc, dc, idx, exp_q.size());
        end

        if (stall_pct == 0 && mask == 32'd0) begin
            tests_run++;
            if (cyc != lc + dc + 1) begin
                tests_failed++;
                $display("FAIL busy_cycles (let=%0d dig=%0d): got %0d, expected %0d",
                         lc, dc, cyc, lc + dc + 1);
            end
        end

        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || char !== 8'h00) begin
            tests_failed++;
            $display("FAIL done_cycle (let=%0d dig=%0d): got done=%b busy=%b valid=%b char=%h, expected done=1 busy=0 valid=0 char=00",
                     lc, dc, done, busy, valid, char);
        end

        if (chain) begin
            start   = 1'b1;
            let_cnt = CNT_W'(nlc);
            dig_cnt = CNT_W'(ndc);
            @(negedge clk);
            start = 1'b0;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL chain_start: got done=%b busy=%b, expected done=0 busy=1", done, busy);
            end
        end else begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_width: got done=%b busy=%b valid=%b, expected done=0 busy=0 valid=0",
                         done, busy, valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        let_cnt = '0;
        dig_cnt = '0;
        ready   = 1'b1;
        #2;
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || char !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%b busy=%b done=%b char=%h, expected 0 0 0 00",
                     valid, busy, done, char);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b, expected 0 0 0",
                     valid, busy, done);
        end
    endtask

    task automatic test_basic();
        run_stream(4, 4, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_zero_counts();
        run_stream(0, 0, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
        run_stream(0, 3, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
        run_stream(2, 0, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        run_stream(28, 11, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
        run_stream(31, 31, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_stall();
        run_stream(2, 1, 0, 32'b111, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_mid_start();
        run_stream(5, 4, 0, 32'd0, 3, 1'b0, 1'b0, 0, 0);
        run_stream(3, 2, 20, 32'd0, 1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_stream(3, 2, 0, 32'd0, -1, 1'b0, 1'b1, 2, 3);
        run_stream(2, 3, 0, 32'd0, -1, 1'b1, 1'b1, 0, 0);
        run_stream(0, 0, 0, 32'd0, -1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start   = 1'b1;
        let_cnt = CNT_W'(2);
        dig_cnt = CNT_W'(5);
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (char !== 8'h31 || valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_digit: got char=%h valid=%b, expected char=31 valid=1", char, valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || char !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b busy=%b done=%b char=%h, expected 0 0 0 00",
                     valid, busy, done, char);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_quiet[%0d]: got done=%b valid=%b busy=%b, expected 0 0 0",
                         i, done, valid, busy);
            end
        end
        run_stream(3, 1, 0, 32'd0, -1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_stream(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                       30, 32'd0, -1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_counts();
        test_wrap();
        test_stall();
        test_mid_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_char_gen.md
# id_char_gen

Streaming identifier generator: on `start` it emits one ASCII character per accepted beat. The stream is `let_cnt` lowercase letters, then `dig_cnt` digits, then the terminator `/`. It is the transmit-side counterpart of the identifier-recognizer FSM and drives that block's `char` input in system benches and loopback tests. A valid/ready handshake lets the consumer stall the stream.

## Interface
- `CNT_W`, default 4: width of the letter and digit count inputs. Counts range 0 to 2^CNT_W-1.
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a new identifier. Sampled only in IDLE.
- `let_cnt`, in, CNT_W: number of letters. Captured with `start`.
- `dig_cnt`, in, CNT_W: number of digits. Captured with `start`.
- `ready`, in, 1: consumer accepts the current `char` when `valid && ready` at a rising edge.
- `char`, out, 8: current ASCII character. Reads 8'h00 when `valid` is 0.
- `valid`, out, 1: `char` holds a character to transfer.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the terminator is accepted.

## Operation
- States: IDLE, LET, DIG, TERM. Encoding comes from the shared package.
- IDLE:
  - `valid`=0, `char`=8'h00, `busy`=0.
  - On `start`=1, capture both counts into the remaining-letter and remaining-digit counters.
  - Next state: LET if `let_cnt`≠0; else DIG if `dig_cnt`≠0; else TERM.
- LET:
  - `char` starts at 8'h61 ('a') for each new identifier.
  - Each accepted beat advances `char` by 1 and decrements the remaining-letter counter.
  - After 8'h7A ('z') the next letter wraps to 'a'.
  - When the last letter is accepted, go to DIG if the captured digit count ≠0, else to TERM.
- DIG:
  - `char` starts at 8'h31 ('1').
  - Each accepted beat advances `char` by 1. After 8'h39 ('9') it wraps to 8'h30 ('0').
  - When the last digit is accepted, go to TERM.
- TERM:
  - `char`=8'h2F ('/').
  - When it is accepted, go to IDLE and assert `done` in that same IDLE cycle.
- Stall: while `valid`=1 and `ready`=0, `char`, the state and both counters hold.
- `start` in LET, DIG or TERM is ignored and has no queued effect.
- `start` in the IDLE cycle where `done`=1 is accepted normally, giving back-to-back identifiers.
- Counter arithmetic:
  - Counters are CNT_W bits, decremented only on an accepted beat, and never underflow, because a zero count skips its state.
  - Character increment is 8-bit with explicit wrap compares. No modulo divider.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE.
  - `valid`=0, `busy`=0, `done`=0, `char`=8'h00, counters 0.
- Reset during LET, DIG or TERM aborts immediately. No terminator is emitted and no `done` pulse follows.
- Latency:
  - `start` is sampled at edge N; the first character is valid in the cycle after edge N.
  - With `ready` held at 1, the stream is one character per cycle.
  - Total `busy` cycles = `let_cnt` + `dig_cnt` + 1 when no stall occurs.
- `done` is high for exactly one cycle, the cycle after the edge that accepted '/'.
- `valid` and `char` are registered outputs. `done` is registered. `busy` may be decoded from the state register.
- The handshake is AXI-style: once `valid` rises it does not fall, and `char` does not change, until the beat is accepted.

## Structure
- Package `id_pkg`:
  - State typedef (IDLE, LET, DIG, TERM).
  - ASCII constants CH_A=8'h61, CH_Z=8'h7A, CH_0=8'h30, CH_1=8'h31, CH_9=8'h39, CH_TERM=8'h2F, CH_NUL=8'h00.
  - The recognizer FSM shares these constants.
- Single module with no sub-module. The FSM, two down-counters and the character register are small enough to keep flat.

## Test plan
- `let_cnt`=4, `dig_cnt`=4, `start` pulsed, `ready`=1 → `char` sequence a b c d 1 2 3 4 / on consecutive cycles. `busy` is high for 9 cycles, then `done` pulses for 1 cycle. The recognizer in loopback sees "abcd1234/".
- `let_cnt`=0, `dig_cnt`=0 → a single '/' in the cycle after `start`, then `done`. `let_cnt`=0, `dig_cnt`=3 → 1 2 3 /.
- With CNT_W=5: `let_cnt`=28, `dig_cnt`=11 → letters a..z a b and digits 1..9 0 1. Checks both wrap points.
- `let_cnt`=2, `dig_cnt`=1, `ready` low for 3 cycles after the first character → 'a' holds with `valid`=1 through the stall. The stream then resumes b 1 /. No character is duplicated or dropped.
- `start` pulsed mid-stream → ignored. A second `start` in the `done` cycle → a new identifier begins on the next cycle.
- `rst_n` asserted low during DIG → outputs reach reset values without waiting for a clock edge. No `done` pulse follows. A `start` after release begins again from 'a'.
